// File: rtl/ctrl_relogio_if.sv
// Signal bundle between the clock controller, the tick/button sources and the counter machines.
// The slave side is the controller; the master side drives ticks, buttons and carries.
interface ctrl_relogio_if;
    logic       ctrl_tick;
    logic       ctrl_btn_mode;
    logic       ctrl_btn_inc;
    logic       ctrl_sec_carry;
    logic       ctrl_min_carry;
    logic       ctrl_sec_enable;
    logic       ctrl_sec_clear;
    logic       ctrl_min_enable;
    logic       ctrl_hr_enable;
    logic [1:0] ctrl_mode;
    logic       ctrl_blink;

    modport master (
        output ctrl_tick, ctrl_btn_mode, ctrl_btn_inc, ctrl_sec_carry, ctrl_min_carry,
        input  ctrl_sec_enable, ctrl_sec_clear, ctrl_min_enable, ctrl_hr_enable,
               ctrl_mode, ctrl_blink
    );

    modport slave (
        input  ctrl_tick, ctrl_btn_mode, ctrl_btn_inc, ctrl_sec_carry, ctrl_min_carry,
        output ctrl_sec_enable, ctrl_sec_clear, ctrl_min_enable, ctrl_hr_enable,
               ctrl_mode, ctrl_blink
    );
endinterface

// File: rtl/ctrl_relogio.sv
// Run/set controller for the HH:MM:SS clock: forwards tick and carries in RUN,
// steps one field per inc press in SET_*, with auto-repeat and an inactivity timeout.
module ctrl_relogio #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int TIMEOUT_S     = 30
) (
    input  logic          ctrl_clock,
    input  logic          ctrl_reset,
    ctrl_relogio_if.slave bus
);
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int PW = $clog2(REPEAT_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;
    state_t state, state_nx;

    logic          mode_s1, mode_s2, mode_h, mode_ev;
    logic          inc_s1, inc_s2, inc_h, inc_ev;
    logic          sec_carry_q, min_carry_q, sec_cev, min_cev;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] per_cnt;
    logic          repeating, rpt_fire;
    logic [TW-1:0] to_cnt, to_nx;
    logic          blink, blink_nx;
    logic          sec_en_q, sec_clr_q, min_en_q, hr_en_q;
    logic          sec_en_nx, sec_clr_nx, min_en_nx, hr_en_nx;

    assign sec_cev  = bus.ctrl_sec_carry & ~sec_carry_q;
    assign min_cev  = bus.ctrl_min_carry & ~min_carry_q;
    // Hold counter waits for the first repeat, then the period counter takes over.
    assign rpt_fire = inc_s2 & (repeating ? (per_cnt == PW'(REPEAT_PERIOD))
                                          : (hold_cnt == HW'(REPEAT_DELAY)));

    assign bus.ctrl_sec_enable = sec_en_q;
    assign bus.ctrl_sec_clear  = sec_clr_q;
    assign bus.ctrl_min_enable = min_en_q;
    assign bus.ctrl_hr_enable  = hr_en_q;
    assign bus.ctrl_mode       = state;
    assign bus.ctrl_blink      = blink;

    always_ff @(posedge ctrl_clock) begin
        if (ctrl_reset) begin
            {mode_s1, mode_s2, mode_h, mode_ev} <= '0;
            {inc_s1, inc_s2, inc_h, inc_ev}     <= '0;
            {sec_carry_q, min_carry_q}          <= '0;
            hold_cnt  <= '0;
            per_cnt   <= '0;
            repeating <= 1'b0;
            state     <= RUN;
            to_cnt    <= '0;
            blink     <= 1'b0;
            {sec_en_q, sec_clr_q, min_en_q, hr_en_q} <= '0;
        end else begin
            mode_s1 <= bus.ctrl_btn_mode;
            mode_s2 <= mode_s1;
            mode_h  <= mode_s2;
            mode_ev <= mode_s2 & ~mode_h;
            inc_s1  <= bus.ctrl_btn_inc;
            inc_s2  <= inc_s1;
            inc_h   <= inc_s2;
            inc_ev  <= (inc_s2 & ~inc_h) | rpt_fire;
            sec_carry_q <= bus.ctrl_sec_carry;
            min_carry_q <= bus.ctrl_min_carry;
            if (!inc_s2) begin
                hold_cnt  <= '0;
                per_cnt   <= '0;
                repeating <= 1'b0;
            end else if (!repeating) begin
                if (rpt_fire) begin
                    repeating <= 1'b1;
                    per_cnt   <= PW'(1);
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end else begin
                per_cnt <= rpt_fire ? PW'(1) : per_cnt + PW'(1);
            end
            state     <= state_nx;
            to_cnt    <= to_nx;
            blink     <= blink_nx;
            sec_en_q  <= sec_en_nx;
            sec_clr_q <= sec_clr_nx;
            min_en_q  <= min_en_nx;
            hr_en_q   <= hr_en_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        to_nx      = to_cnt;
        blink_nx   = blink;
        sec_en_nx  = 1'b0;
        sec_clr_nx = 1'b0;
        min_en_nx  = 1'b0;
        hr_en_nx   = 1'b0;
        if (state == RUN) begin
            to_nx     = '0;
            blink_nx  = 1'b0;
            sec_en_nx = bus.ctrl_tick;
            min_en_nx = sec_cev;
            hr_en_nx  = min_cev;
            if (mode_ev) state_nx = SET_HR;
        end else begin
            if (bus.ctrl_tick) begin
                to_nx    = to_cnt + TW'(1);
                blink_nx = ~blink;
            end
            // Mode beats timeout beats inc; tick and carry events are dropped here.
            if (mode_ev) begin
                case (state)
                    SET_HR:  state_nx = SET_MIN;
                    SET_MIN: state_nx = SET_SEC;
                    default: state_nx = RUN;
                endcase
                to_nx    = '0;
                blink_nx = 1'b0;
            end else if (to_cnt == TW'(TIMEOUT_S)) begin
                state_nx = RUN;
                to_nx    = '0;
                blink_nx = 1'b0;
            end else if (inc_ev) begin
                to_nx = '0;
                case (state)
                    SET_HR:  hr_en_nx   = 1'b1;
                    SET_MIN: min_en_nx  = 1'b1;
                    default: sec_clr_nx = 1'b1;
                endcase
            end
        end
    end
endmodule
